// File: rtl/dmem_ctrl_if.sv
// Request/response channel between one requester (core or loader) and dmem_ctrl.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Two-port arbiter/sequencer for the single-port data memory; partial stores use read-modify-write.
// Define DMEM_CTRL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_ctrl #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    dmem_ctrl_if.slave    p0,
    dmem_ctrl_if.slave    p1,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RMW_WR = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    logic [1:0]  state;
    logic        cur_port;
    logic        cur_we;
    logic        cur_oor;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    logic        wr_en_q;
    logic [1:0]  rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        grant1;
    logic        accept;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        sel_oor;
    logic        partial;
    logic [31:0] merged;

`ifdef DMEM_CTRL_RR_EN
    logic last_grant;

    // last_grant resets to 1 so the first contention goes to port 0
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end

    assign grant1 = p1.req_valid && (!p0.req_valid || (last_grant == 1'b0));
`else
    assign grant1 = p1.req_valid && !p0.req_valid;
`endif

    assign accept       = (state == S_IDLE) && !rst && (p0.req_valid || p1.req_valid);
    assign p0.req_ready = accept && !grant1;
    assign p1.req_ready = accept && grant1;

    assign sel_we    = grant1 ? p1.req_we    : p0.req_we;
    assign sel_addr  = grant1 ? p1.req_addr  : p0.req_addr;
    assign sel_be    = grant1 ? p1.req_be    : p0.req_be;
    assign sel_wdata = grant1 ? p1.req_wdata : p0.req_wdata;
    assign sel_oor   = (sel_addr >= ADDR_LIMIT);

    assign partial = cur_we && !cur_oor && (cur_be != 4'h0) && (cur_be != 4'hF);

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (cur_be[i])
                merged[8*i +: 8] = cur_wdata[8*i +: 8];
        end
    end

    // Write strobe and responses are masked while rst is high so an abandoned access has no effect
    assign mem_wr_en = wr_en_q && !rst;

    assign p0.rsp_valid = rsp_valid_q[0] && !rst;
    assign p0.rsp_err   = p0.rsp_valid && rsp_err_q;
    assign p0.rsp_rdata = p0.rsp_valid ? rsp_rdata_q : 32'h0;
    assign p1.rsp_valid = rsp_valid_q[1] && !rst;
    assign p1.rsp_err   = p1.rsp_valid && rsp_err_q;
    assign p1.rsp_rdata = p1.rsp_valid ? rsp_rdata_q : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            cur_oor     <= 1'b0;
            cur_be      <= 4'h0;
            cur_wdata   <= 32'h0;
            wr_en_q     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_ACCESS;
                        cur_port  <= grant1;
                        cur_we    <= sel_we;
                        cur_oor   <= sel_oor;
                        cur_be    <= sel_be;
                        cur_wdata <= sel_wdata;
                        mem_addr  <= sel_addr[AW+1:2];
                        // Full-word stores write directly during ACCESS
                        if (sel_we && (sel_be == 4'hF) && !sel_oor) begin
                            wr_en_q   <= 1'b1;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    wr_en_q <= 1'b0;
                    if (partial) begin
                        state     <= S_RMW_WR;
                        wr_en_q   <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state                 <= S_RESP;
                        rsp_valid_q[cur_port] <= 1'b1;
                        rsp_err_q             <= cur_oor;
                        rsp_rdata_q           <= (!cur_we && !cur_oor) ? mem_rdata : 32'h0;
                    end
                end
                S_RMW_WR: begin
                    wr_en_q               <= 1'b0;
                    state                 <= S_RESP;
                    rsp_valid_q[cur_port] <= 1'b1;
                    rsp_err_q             <= 1'b0;
                    rsp_rdata_q           <= 32'h0;
                end
                default: begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 2'b00;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_ctrl;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem     [0:DEPTH-1];
    logic [31:0]   ref_mem [0:DEPTH-1];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    dmem_ctrl_if p0 ();
    dmem_ctrl_if p1 ();

    dmem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0),
        .p1        (p1),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with combinational read
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) * 32'h9E3779B1;
        forever begin
            @(posedge clk);
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        end
    end

    function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    task automatic drive(input logic port, input logic v, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (port) begin
            p1.req_valid = v; p1.req_we = we; p1.req_addr = addr; p1.req_be = be; p1.req_wdata = wd;
        end else begin
            p0.req_valid = v; p0.req_we = we; p0.req_addr = addr; p0.req_be = be; p0.req_wdata = wd;
        end
    endtask

    // Issues one request and records what the DUT did; the callers judge the observations
    task automatic run_txn(input logic port, input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, output int acc_cyc, output int lat,
                           output logic [31:0] rdata, output logic err, output int nwr, output int wr_k,
                           output logic [AW-1:0] wr_addr, output logic [31:0] wr_data,
                           output logic other_bad, output logic timeout);
        logic got;
        acc_cyc = -1; lat = -1; rdata = 32'h0; err = 1'b0; nwr = 0; wr_k = -1;
        wr_addr = '0; wr_data = 32'h0; other_bad = 1'b0; timeout = 1'b0; got = 1'b0;
        @(negedge clk);
        drive(port, 1'b1, we, addr, be, wdata);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port ? p1.req_ready : p0.req_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            timeout = 1'b1;
            drive(port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) drive(port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (mem_wr_en === 1'b1) begin
                nwr++; wr_k = k; wr_addr = mem_addr; wr_data = mem_wdata;
            end
            if (port ? (p0.rsp_valid !== 1'b0 || p0.rsp_err !== 1'b0 || p0.rsp_rdata !== 32'h0)
                     : (p1.rsp_valid !== 1'b0 || p1.rsp_err !== 1'b0 || p1.rsp_rdata !== 32'h0))
                other_bad = 1'b1;
            if ((port ? p1.rsp_valid : p0.rsp_valid) === 1'b1) begin
                lat = k;
                rdata = port ? p1.rsp_rdata : p0.rsp_rdata;
                err = port ? p1.rsp_err : p0.rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({p0.req_ready, p1.req_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {p0.req_ready, p1.req_ready});
        end
        checks++;
        if ({p0.rsp_valid, p1.rsp_valid, p0.rsp_err, p1.rsp_err} !== 4'b0000 ||
            p0.rsp_rdata !== 32'h0 || p1.rsp_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rsp: got v=%b%b e=%b%b rd0=%h rd1=%h expected all 0",
                               p0.rsp_valid, p1.rsp_valid, p0.rsp_err, p1.rsp_err, p0.rsp_rdata, p1.rsp_rdata);
        end
        checks++;
        if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_mem: got we=%b addr=%h wdata=%h expected 0", mem_wr_en, mem_addr, mem_wdata);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;
    endtask

    task automatic test_full_store_load();
        int ac, lat, nwr, wk; logic [31:0] rd, wd; logic er, ob, to; logic [AW-1:0] wa;
        run_txn(1'b0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        ref_mem[16] = 32'hDEADBEEF;
        checks++;
        if (to || lat != 2 || nwr != 1 || wk != 1) begin
            errors++; $display("[TB] FAIL full_store_timing: got to=%b lat=%0d nwr=%0d wk=%0d expected 0/2/1/1", to, lat, nwr, wk);
        end
        checks++;
        if (wa !== 11'd16 || wd !== 32'hDEADBEEF || rd !== 32'h0 || er !== 1'b0 || ob) begin
            errors++; $display("[TB] FAIL full_store_data: got addr=%0d data=%h rd=%h err=%b ob=%b expected 16 deadbeef 0 0 0", wa, wd, rd, er, ob);
        end
        run_txn(1'b0, 1'b0, 32'h40, 4'h0, 32'h0, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || nwr != 0 || rd !== 32'hDEADBEEF || er !== 1'b0 || ob) begin
            errors++; $display("[TB] FAIL load_after_store: got to=%b lat=%0d nwr=%0d rd=%h err=%b expected lat 2 rd deadbeef", to, lat, nwr, rd, er);
        end
    endtask

    task automatic test_partial_store();
        int ac, lat, nwr, wk; logic [31:0] rd, wd; logic er, ob, to; logic [AW-1:0] wa;
        run_txn(1'b0, 1'b1, 32'h40, 4'b0010, 32'h0000AA00, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        ref_mem[16] = 32'hDEADAAEF;
        checks++;
        if (to || lat != 3 || nwr != 1 || wk != 2) begin
            errors++; $display("[TB] FAIL rmw_timing: got to=%b lat=%0d nwr=%0d wk=%0d expected 0/3/1/2", to, lat, nwr, wk);
        end
        checks++;
        if (wa !== 11'd16 || wd !== 32'hDEADAAEF || er !== 1'b0) begin
            errors++; $display("[TB] FAIL rmw_data: got addr=%0d data=%h err=%b expected 16 deadaaef 0", wa, wd, er);
        end
        run_txn(1'b1, 1'b1, 32'h43, 4'h0, 32'h12345678, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || nwr != 0 || er !== 1'b0 || ob) begin
            errors++; $display("[TB] FAIL be_zero_store: got to=%b lat=%0d nwr=%0d err=%b expected lat 2 no write", to, lat, nwr, er);
        end
        run_txn(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || rd !== 32'hDEADAAEF || ob) begin
            errors++; $display("[TB] FAIL load_after_rmw: got lat=%0d rd=%h expected 2 deadaaef", lat, rd);
        end
    endtask

    task automatic test_out_of_range();
        int ac, lat, nwr, wk; logic [31:0] rd, wd; logic er, ob, to; logic [AW-1:0] wa;
        run_txn(1'b1, 1'b0, 32'h2000, 4'h0, 32'h0, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || nwr != 0 || rd !== 32'h0 || er !== 1'b1 || ob) begin
            errors++; $display("[TB] FAIL oor_load: got lat=%0d nwr=%0d rd=%h err=%b expected 2 0 0 1", lat, nwr, rd, er);
        end
        run_txn(1'b0, 1'b1, 32'h2000, 4'hF, 32'hCAFEF00D, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || nwr != 0 || rd !== 32'h0 || er !== 1'b1 || ob) begin
            errors++; $display("[TB] FAIL oor_full_store: got lat=%0d nwr=%0d rd=%h err=%b expected 2 0 0 1", lat, nwr, rd, er);
        end
        run_txn(1'b0, 1'b1, 32'h2004, 4'b0100, 32'h00AB0000, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || nwr != 0 || er !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_partial_store: got lat=%0d nwr=%0d err=%b expected 2 0 1", lat, nwr, er);
        end
        run_txn(1'b1, 1'b0, 32'h1FFC, 4'h0, 32'h0, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || rd !== ref_mem[DEPTH-1] || er !== 1'b0) begin
            errors++; $display("[TB] FAIL last_word_load: got lat=%0d rd=%h err=%b expected 2 %h 0", lat, rd, er, ref_mem[DEPTH-1]);
        end
    endtask

    task automatic test_back_to_back();
        int ac[4], lat, nwr, wk; logic [31:0] rd, wd; logic er, ob, to; logic [AW-1:0] wa;
        run_txn(1'b0, 1'b1, 32'h80, 4'hF, 32'h11223344, ac[0], lat, rd, er, nwr, wk, wa, wd, ob, to);
        ref_mem[32] = 32'h11223344;
        run_txn(1'b0, 1'b1, 32'h84, 4'b1000, 32'h55000000, ac[1], lat, rd, er, nwr, wk, wa, wd, ob, to);
        ref_mem[33] = model_merge(ref_mem[33], 32'h55000000, 4'b1000);
        run_txn(1'b1, 1'b0, 32'h84, 4'h0, 32'h0, ac[2], lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (rd !== ref_mem[33]) begin
            errors++; $display("[TB] FAIL b2b_load: got %h expected %h", rd, ref_mem[33]);
        end
        run_txn(1'b0, 1'b0, 32'h80, 4'h0, 32'h0, ac[3], lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (ac[1] - ac[0] != 3 || ac[2] - ac[1] != 4 || ac[3] - ac[2] != 3) begin
            errors++; $display("[TB] FAIL b2b_spacing: got %0d %0d %0d expected 3 4 3", ac[1]-ac[0], ac[2]-ac[1], ac[3]-ac[2]);
        end
    endtask

    task automatic test_random();
        int ac, lat, nwr, wk, e_lat, e_nwr, e_wk; logic [31:0] rd, wd, e_rd, e_wd, addr, wdata;
        logic er, ob, to, port, we, oor; logic [3:0] be; logic [AW-1:0] wa, w;
        for (int n = 0; n < 40; n++) begin
            port  = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            be    = 4'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) addr = 32'h2000 + 32'($urandom_range(0, 4000));
            else addr = 32'($urandom_range(0, 127));
            oor   = (addr >= 32'(DEPTH * 4));
            w     = addr[AW+1:2];
            e_rd  = (!we && !oor) ? ref_mem[w] : 32'h0;
            e_nwr = (we && !oor && be != 4'h0) ? 1 : 0;
            e_wk  = (be == 4'hF) ? 1 : 2;
            e_lat = (e_nwr == 1 && be != 4'hF) ? 3 : 2;
            e_wd  = model_merge(ref_mem[w], wdata, be);
            run_txn(port, we, addr, be, wdata, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
            if (e_nwr == 1) ref_mem[w] = e_wd;
            checks++;
            if (to || lat != e_lat || rd !== e_rd || er !== oor || ob) begin
                errors++; $display("[TB] FAIL rand_rsp[%0d]: got to=%b lat=%0d rd=%h err=%b ob=%b expected lat=%0d rd=%h err=%b",
                                   n, to, lat, rd, er, ob, e_lat, e_rd, oor);
            end
            checks++;
            if (nwr != e_nwr || (e_nwr == 1 && (wk != e_wk || wa !== w || wd !== e_wd))) begin
                errors++; $display("[TB] FAIL rand_write[%0d]: got n=%0d k=%0d a=%0d d=%h expected n=%0d k=%0d a=%0d d=%h",
                                   n, nwr, wk, wa, wd, e_nwr, e_wk, w, e_wd);
            end
        end
    endtask

    task automatic test_contention();
        int grants[$]; logic [31:0] exp0[$], exp1[$]; logic [31:0] a0, a1; logic r0, r1, p1_done; int exp_g, p1_wins;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        a0 = 32'h100; a1 = 32'h300; p1_done = 1'b0; p1_wins = 0;
        drive(1'b0, 1'b1, 1'b0, a0, 4'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, a1, 4'h0, 32'h0);
        for (int c = 0; c < 60; c++) begin
            #1;
            if (p0.rsp_valid === 1'b1) begin
                checks++;
                if (exp0.size() == 0 || p0.rsp_rdata !== exp0[0]) begin
                    errors++; $display("[TB] FAIL cont_rsp0: got %h expected %h", p0.rsp_rdata, exp0.size() ? exp0[0] : 32'h0);
                end
                if (exp0.size() != 0) void'(exp0.pop_front());
            end
            if (p1.rsp_valid === 1'b1) begin
                checks++;
                if (exp1.size() == 0 || p1.rsp_rdata !== exp1[0]) begin
                    errors++; $display("[TB] FAIL cont_rsp1: got %h expected %h", p1.rsp_rdata, exp1.size() ? exp1[0] : 32'h0);
                end
                if (exp1.size() != 0) void'(exp1.pop_front());
            end
            r0 = p0.req_ready; r1 = p1.req_ready;
            if (r0 === 1'b1 && r1 === 1'b1) begin
                checks++; errors++; $display("[TB] FAIL cont_double_grant: got 11 expected one");
            end
            if (r0 === 1'b1) begin grants.push_back(0); exp0.push_back(ref_mem[a0[AW+1:2]]); end
            if (r1 === 1'b1) begin
                if (grants.size() < 6) begin grants.push_back(1); p1_wins++; end
                else p1_done = 1'b1;
                exp1.push_back(ref_mem[a1[AW+1:2]]);
            end
            if (p1_done && exp0.size() == 0 && exp1.size() == 0) break;
            @(posedge clk);
            @(negedge clk);
            if (r0 === 1'b1) begin a0 = a0 + 4; drive(1'b0, grants.size() < 6, 1'b0, a0, 4'h0, 32'h0); end
            if (r1 === 1'b1) begin a1 = a1 + 4; drive(1'b1, !p1_done, 1'b0, a1, 4'h0, 32'h0); end
            if (grants.size() >= 6) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (grants.size() != 6) begin
            errors++; $display("[TB] FAIL cont_grant_count: got %0d expected 6", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
`ifdef DMEM_CTRL_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            checks++;
            if (grants[i] != exp_g) begin
                errors++; $display("[TB] FAIL cont_grant[%0d]: got port %0d expected port %0d", i, grants[i], exp_g);
            end
        end
        checks++;
        if (!p1_done || exp0.size() != 0 || exp1.size() != 0) begin
            errors++; $display("[TB] FAIL cont_drain: got p1_done=%b pending=%0d/%0d expected 1 0/0", p1_done, exp0.size(), exp1.size());
        end
`ifdef DMEM_CTRL_RR_EN
        exp_g = 3;
`else
        exp_g = 0;
`endif
        checks++;
        if (p1_wins != exp_g) begin
            errors++; $display("[TB] FAIL cont_p1_wins: got %0d expected %0d", p1_wins, exp_g);
        end
    endtask

    task automatic test_reset_mid(input logic [3:0] be, input logic [31:0] addr);
        int ac, lat, nwr, wk, pulses, writes; logic [31:0] rd, wd; logic er, ob, to, got; logic [AW-1:0] wa;
        got = 1'b0; pulses = 0; writes = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, addr, be, 32'hA5A5A5A5);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (p0.req_ready === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++; $display("[TB] FAIL rstmid_accept: got no ready expected ready");
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_wr_in_reset be=%h: got %b expected 0", be, mem_wr_en);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 ||
            {p0.rsp_valid, p1.rsp_valid, p0.rsp_err, p1.rsp_err} !== 4'b0 || p0.rsp_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL rstmid_outputs: got we=%b addr=%h wd=%h v=%b%b expected all 0",
                               mem_wr_en, mem_addr, mem_wdata, p0.rsp_valid, p1.rsp_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_wr_en === 1'b1) writes++;
            if (p0.rsp_valid === 1'b1 || p1.rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (writes != 0 || pulses != 0 || mem[addr[AW+1:2]] !== ref_mem[addr[AW+1:2]]) begin
            errors++; $display("[TB] FAIL rstmid_abandon: got writes=%0d pulses=%0d word=%h expected 0 0 %h",
                               writes, pulses, mem[addr[AW+1:2]], ref_mem[addr[AW+1:2]]);
        end
        run_txn(1'b0, 1'b0, addr, 4'h0, 32'h0, ac, lat, rd, er, nwr, wk, wa, wd, ob, to);
        checks++;
        if (to || lat != 2 || rd !== ref_mem[addr[AW+1:2]] || er !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_fresh_load: got lat=%0d rd=%h expected 2 %h", lat, rd, ref_mem[addr[AW+1:2]]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        test_reset();
        test_full_store_load();
        test_partial_store();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_contention();
        test_reset_mid(4'b0001, 32'h120);
        test_reset_mid(4'hF, 32'h124);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Two-port access controller in front of the single-port word-addressed data memory. It arbitrates between the core load/store port (port 0) and the debug/loader port (port 1), and sequences each transaction onto the memory. Partial-word stores are done as read-modify-write using byte enables, because the memory only writes whole 32-bit words. The block sits between the core/loader and the memory; the memory's combinational read port feeds `mem_rdata`.

## Interface
- `DEPTH`, 2048: memory depth in 32-bit words; byte addresses ≥ `DEPTH*4` are out of range.
- `AW`, 11: word-address width, equal to clog2(`DEPTH`).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `pN_req_valid` in 1 (N=0,1): request valid; held with payload stable until accepted.
- `pN_req_ready` out 1: request accepted this cycle.
- `pN_req_we` in 1: 1 = store, 0 = load.
- `pN_req_addr` in 32: byte address; bits [1:0] ignored.
- `pN_req_be` in 4: store byte enables; ignored for loads.
- `pN_req_wdata` in 32: store data, byte lanes aligned.
- `pN_rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `pN_rsp_rdata` out 32: full load word; 0 for stores and errors.
- `pN_rsp_err` out 1: out-of-range address; valid with `pN_rsp_valid`.
- `mem_wr_en` out 1: memory write strobe.
- `mem_addr` out `AW`: memory word address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory combinational read data.

## Operation
- FSM states:
  - IDLE: arbitrate, accept.
  - ACCESS: drive `mem_addr`; load captures `mem_rdata`; full store (be=4'hF) asserts `mem_wr_en`.
  - RMW_WR: write merged word.
  - RESP: pulse response.
- Transitions:
  - IDLE→ACCESS on accept.
  - ACCESS→RMW_WR only for stores with be ∉ {4'h0, 4'hF} and in range.
  - ACCESS→RESP otherwise.
  - RMW_WR→RESP.
  - RESP→IDLE.
- Accept: `pN_req_ready` = (state==IDLE) && `pN_req_valid` && granted N; never asserted during `rst`. Address, we, be, wdata and the port ID are latched on accept.
- Merge: byte i = be[i] ? wdata byte i : captured word byte i.
- Store with be=4'h0: no memory write; normal response.
- Out of range:
  - `mem_wr_en` is never asserted.
  - rdata = 0, err = 1.
  - Latency is that of a load.
- Response goes only to the port that issued the request. The other port's rsp outputs stay 0.
- `mem_wr_en` is high only in ACCESS (full store) or RMW_WR. When `mem_wr_en` is low, `mem_wdata` holds its last value.

## Timing
- Reset values: all `pN_req_ready`, `pN_rsp_valid`, `pN_rsp_err`, `pN_rsp_rdata`, `mem_wr_en`, `mem_addr` and `mem_wdata` are 0. State resets to IDLE. The round-robin pointer favours port 0.
- Accept at cycle T gives:
  - Load, full store, be=0 store, or error: rsp_valid at T+2.
  - Partial store: memory write at T+2, rsp_valid at T+3.
- Throughput: one transaction per 3 cycles (full/load) or 4 cycles (partial). No accept in ACCESS, RMW_WR or RESP.
- Simultaneous valid on both ports in IDLE: exactly one grant, per the Configuration section. The loser keeps valid high and is accepted at the next IDLE.
- `rst` mid-transaction:
  - The transaction is abandoned with no response.
  - `mem_wr_en` is 0 in the reset cycle.
  - A pending RMW write is dropped.

## Configuration
- `DMEM_CTRL_RR_EN` defined: round-robin arbitration. On contention, grant the port not granted last. The pointer updates on every accept.
- Not defined: fixed priority; port 0 always wins contention, and port 1 can starve.

## Test plan
- Full store then load, port 0: store addr 0x40, be=F, data 0xDEADBEEF. Expect `mem_wr_en` at T+1 with `mem_addr`=16 and rsp at T+2. A load of 0x40 then returns 0xDEADBEEF with err=0 at T+2.
- Partial store RMW: word 0x40 holds 0xDEADBEEF; store be=4'b0010, data 0x0000AA00. Expect one write of 0xDEADAAEF at T+2 and rsp at T+3.
- Contention: both ports valid every cycle with distinct loads.
  - With `DMEM_CTRL_RR_EN`: grants alternate 0,1,0,1.
  - Without it: port 1 is never granted while port 0 stays valid.
- Out of range: load or store at 0x2000 (DEPTH=2048). Expect no `mem_wr_en`, rsp_err=1 and rdata=0 at T+2.
- Reset mid-RMW: assert `rst` in the ACCESS cycle of a be=4'b0001 store. Expect no write to the memory, no rsp_valid, and all outputs 0 in the next cycle; a fresh load then completes normally.
